aes_round_ctrl: RTL and testbench

Iterative AES-128 encryption sequencer. It owns the state and round-key registers, round counter and Rcon generator, and drives a shared single-round datapath one round per cycle. The datapath is external combinational logic: SubBytes, then aes_shift, then MixColumns (bypassed on the last round), then AddRoundKey. A separate external combinational key-expansion step supplies the round keys. Valid/ready handshakes on both the block input and the block output.

---
 rtl/aes_round_ctrl.sv | 144 ++++++++++++++
 tb/tb_aes_round_ctrl.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encryption sequencer: holds state, round key, round count and Rcon,
// and steps an external combinational round datapath plus key expansion once per cycle.
module aes_round_ctrl #(
    parameter int ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] data_in,
    input  logic [127:0] key_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out,
    output logic [127:0] rd_state,
    output logic [127:0] rd_key,
    output logic         rd_last,
    input  logic [127:0] rd_result,
    output logic [127:0] kx_key,
    output logic [7:0]   kx_rcon,
    input  logic [127:0] kx_next,
    output logic         busy,
    output logic [3:0]   round
);

    generate
        if (ROUNDS != 10) begin : g_rounds_check
            $error("aes_round_ctrl: only ROUNDS=10 (AES-128) is supported");
        end
    endgenerate

    localparam logic [3:0] LAST_ROUND = 4'(ROUNDS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fsm_t;

    fsm_t         fsm_q, fsm_d;
    logic [127:0] state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [127:0] dout_q, dout_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [3:0]   round_q, round_d;
    logic         accept;
    logic         is_last;

    function automatic logic [7:0] xtime(input logic [7:0] r);
        return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
    endfunction

    assign accept  = in_valid && in_ready;
    assign is_last = (round_q == LAST_ROUND);

    // State register process
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q   <= ST_IDLE;
            state_q <= '0;
            key_q   <= '0;
            dout_q  <= '0;
            rcon_q  <= 8'h01;
            round_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            key_q   <= key_d;
            dout_q  <= dout_d;
            rcon_q  <= rcon_d;
            round_q <= round_d;
        end
    end

    // Next-state process
    always_comb begin
        fsm_d = fsm_q;
        unique case (fsm_q)
            ST_IDLE: if (accept) fsm_d = ST_RUN;
            ST_RUN:  if (is_last) fsm_d = ST_DONE;
            ST_DONE: begin
                // A fresh accept during the output handshake skips IDLE entirely.
                if (accept)
                    fsm_d = ST_RUN;
                else if (out_ready)
                    fsm_d = ST_IDLE;
            end
            default: fsm_d = ST_IDLE;
        endcase
    end

    // Register updates; accept only happens in IDLE/DONE so it never collides with RUN.
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        dout_d  = dout_q;
        rcon_d  = rcon_q;
        round_d = round_q;
        if (accept) begin
            state_d = data_in ^ key_in;
            key_d   = key_in;
            rcon_d  = 8'h01;
            round_d = 4'd1;
        end else if (fsm_q == ST_RUN) begin
            state_d = rd_result;
            key_d   = kx_next;
            rcon_d  = xtime(rcon_q);
            if (is_last)
                dout_d = rd_result;
            else
                round_d = round_q + 4'd1;
        end
    end

    // Output process
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        rd_last   = 1'b0;
        rd_key    = key_q;
        unique case (fsm_q)
            ST_IDLE: in_ready = 1'b1;
            ST_RUN: begin
                busy    = 1'b1;
                rd_last = is_last;
                rd_key  = kx_next;
            end
            ST_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                in_ready  = out_ready;
            end
            default: ;
        endcase
    end

    assign rd_state = state_q;
    assign kx_key   = key_q;
    assign kx_rcon  = rcon_q;
    assign data_out = dout_q;
    assign round    = round_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: models the external round datapath and key expansion,
// and scores ciphertexts against FIPS-197 vectors through an expected-result queue.
module tb_aes_round_ctrl;

    localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] C_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] data_in;
    logic [127:0] key_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] data_out;
    logic [127:0] rd_state;
    logic [127:0] rd_key;
    logic         rd_last;
    logic [127:0] rd_result;
    logic [127:0] kx_key;
    logic [7:0]   kx_rcon;
    logic [127:0] kx_next;
    logic         busy;
    logic [3:0]   round;

    typedef struct {
        logic [127:0] exp;
        int           acc;
    } sb_item_t;

    sb_item_t     sb[$];
    int           out_cyc_q[$];
    logic [127:0] cur_exp;
    int           cyc;
    int           n_checks;
    int           n_fail;
    int           n_out;
    bit           head_seen;
    logic [7:0]   rcon_tab[10];

    aes_round_ctrl #(.ROUNDS(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .key_in    (key_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .rd_state  (rd_state),
        .rd_key    (rd_key),
        .rd_last   (rd_last),
        .rd_result (rd_result),
        .kx_key    (kx_key),
        .kx_rcon   (kx_rcon),
        .kx_next   (kx_next),
        .busy      (busy),
        .round     (round)
    );

    // ---------------- AES reference pieces for the external datapath ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] inv;
        p   = a;
        inv = 8'h01;
        // a^254 is the field inverse (and maps 0 to 0).
        for (int i = 0; i < 7; i++) begin
            p   = gmul(p, p);
            inv = gmul(inv, p);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic last);
        logic [7:0]   a[16];
        logic [7:0]   t[16];
        logic [7:0]   m0, m1, m2, m3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) a[i] = sbox(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[r+4*c] = a[r + 4*((c + r) % 4)];
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                m0 = t[4*c]; m1 = t[4*c+1]; m2 = t[4*c+2]; m3 = t[4*c+3];
                t[4*c]   = gmul(m0, 8'h02) ^ gmul(m1, 8'h03) ^ m2 ^ m3;
                t[4*c+1] = m0 ^ gmul(m1, 8'h02) ^ gmul(m2, 8'h03) ^ m3;
                t[4*c+2] = m0 ^ m1 ^ gmul(m2, 8'h02) ^ gmul(m3, 8'h03);
                t[4*c+3] = gmul(m0, 8'h03) ^ m1 ^ m2 ^ gmul(m3, 8'h02);
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
        return o ^ k;
    endfunction

    function automatic logic [127:0] kexp(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        {w0, w1, w2, w3} = k;
        t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    assign rd_result = aes_round(rd_state, rd_key, rd_last);
    assign kx_next   = kexp(kx_key, kx_rcon);

    // ---------------- clock, cycle count, checking ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Output monitor: latency on first sight of out_valid, data on handshake, push on accept.
    initial begin
        head_seen = 1'b0;
        n_out     = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                sb.delete();
                head_seen = 1'b0;
            end else begin
                if (out_valid && !head_seen) begin
                    if (sb.size() == 0)
                        check_val("spurious_out_valid", 128'(out_valid), 128'(0));
                    else
                        check_val("latency", 128'(cyc - sb[0].acc), 128'(10));
                    head_seen = 1'b1;
                end
                if (out_valid && out_ready) begin
                    if (sb.size() != 0) begin
                        sb_item_t e;
                        e = sb.pop_front();
                        check_val("data_out", data_out, e.exp);
                        $display("[tb] out %0d cyc=%0d data_out=%h", n_out, cyc, data_out);
                        n_out++;
                        out_cyc_q.push_back(cyc);
                    end
                    head_seen = 1'b0;
                end
                if (in_valid && in_ready)
                    sb.push_back('{exp: cur_exp, acc: cyc + 1});
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers (called at posedge+1) ----------------
    task automatic drive_block(input logic [127:0] pt, input logic [127:0] key,
                               input logic [127:0] exp, input bit keep_valid);
        int n;
        n        = 0;
        data_in  = pt;
        key_in   = key;
        cur_exp  = exp;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_val("accept_timeout", 128'(n < 40), 128'(1));
        @(posedge clk);
        #1;
        if (!keep_valid) in_valid = 1'b0;
    endtask

    task automatic watch_run(input bit chk_key);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_val("kx_rcon", 128'(kx_rcon), 128'(rcon_tab[i]));
            check_val("rd_last", 128'(rd_last), 128'(i == 9));
            check_val("round", 128'(round), 128'(i + 1));
            if (chk_key && i == 0) check_val("rd_key_r1", rd_key, B_RK1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        @(negedge clk);
        while ((sb.size() != 0 || busy) && n < 60) begin
            @(negedge clk);
            n++;
        end
        check_val("drain_timeout", 128'(n < 60), 128'(1));
        @(posedge clk);
        #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [127:0] s_pt[4];
        logic [127:0] s_key[4];
        logic [127:0] s_ct[4];
        int           base;
        int           n;

        n_checks = 0;
        n_fail   = 0;
        rcon_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
        s_pt     = '{B_PT, C_PT, B_PT, C_PT};
        s_key    = '{B_KEY, C_KEY, B_KEY, C_KEY};
        s_ct     = '{B_CT, C_CT, B_CT, C_CT};
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        data_in   = '0;
        key_in    = '0;
        cur_exp   = '0;

        repeat (2) @(posedge clk);
        #1;
        check_val("rst_busy", 128'(busy), 128'(0));
        check_val("rst_in_ready", 128'(in_ready), 128'(1));
        check_val("rst_out_valid", 128'(out_valid), 128'(0));
        check_val("rst_round", 128'(round), 128'(0));
        check_val("rst_data_out", data_out, 128'(0));
        check_val("rst_kx_rcon", 128'(kx_rcon), 128'(8'h01));
        rst = 1'b0;
        @(posedge clk);
        #1;

        // FIPS-197 App. B with first-round key check
        drive_block(B_PT, B_KEY, B_CT, 1'b0);
        watch_run(1'b1);
        wait_drain();

        // FIPS-197 App. C.1 with Rcon / rd_last sequence
        drive_block(C_PT, C_KEY, C_CT, 1'b0);
        watch_run(1'b0);
        wait_drain();

        // Backpressure in DONE, then simultaneous handshake and accept
        out_ready = 1'b0;
        drive_block(C_PT, C_KEY, C_CT, 1'b0);
        n = 0;
        while (!out_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        check_val("bp_wait_timeout", 128'(n < 30), 128'(1));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            data_in  = B_PT;
            key_in   = B_KEY;
            cur_exp  = B_CT;
            in_valid = 1'b1;
            @(negedge clk);
            check_val("bp_out_valid", 128'(out_valid), 128'(1));
            check_val("bp_in_ready", 128'(in_ready), 128'(0));
            check_val("bp_data_out", data_out, C_CT);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check_val("b2b_in_ready", 128'(in_ready), 128'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_drain();

        // in_valid pulsed with another block during RUN must be ignored
        drive_block(B_PT, B_KEY, B_CT, 1'b0);
        data_in  = C_PT;
        key_in   = C_KEY;
        cur_exp  = C_CT;
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_val("run_in_ready", 128'(in_ready), 128'(0));
            check_val("run_busy", 128'(busy), 128'(1));
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_drain();

        // Asynchronous reset at round 5
        drive_block(B_PT, B_KEY, B_CT, 1'b0);
        n = 0;
        while (round != 4'd5 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_val("round5_timeout", 128'(n < 20), 128'(1));
        #2;
        rst = 1'b1;
        #1;
        check_val("arst_busy", 128'(busy), 128'(0));
        check_val("arst_in_ready", 128'(in_ready), 128'(1));
        check_val("arst_out_valid", 128'(out_valid), 128'(0));
        check_val("arst_round", 128'(round), 128'(0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        drive_block(B_PT, B_KEY, B_CT, 1'b0);
        wait_drain();

        // Streaming four blocks back to back
        base = out_cyc_q.size();
        for (int k = 0; k < 4; k++)
            drive_block(s_pt[k], s_key[k], s_ct[k], k != 3);
        wait_drain();
        check_val("stream_count", 128'(out_cyc_q.size() - base), 128'(4));
        if (out_cyc_q.size() >= base + 4) begin
            for (int k = 1; k < 4; k++)
                check_val("stream_gap", 128'(out_cyc_q[base+k] - out_cyc_q[base+k-1]), 128'(11));
        end
        check_val("sb_empty", 128'(sb.size()), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
